bullet_hit_ctrl: RTL and testbench

//  Downstream consumer of the bullet mover: each frame compares the live bullet box with one target box.
//  On a hit it retires the bullet, runs the target through hit-flash / dead / respawn phases, and keeps a 4-digit BCD score.

---
 rtl/game_pkg.sv | 38 +++
 rtl/bcd_score_acc.sv | 29 ++
 rtl/bullet_hit_ctrl.sv | 127 ++++++++++++
 tb/tb_bullet_hit_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: target state encoding, screen limits, key codes
// and the saturating BCD adder used by the score accumulators.
package game_pkg;

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    HIT   = 2'd1,
    DEAD  = 2'd2
  } target_state_t;

  localparam int        SCREEN_X_MAX = 639;
  localparam int        SCREEN_Y_MAX = 479;
  localparam logic [7:0] KEY_FIRE    = 8'd44;

  // Adds a single BCD digit to a 4-digit BCD value, rippling the carry digit
  // by digit. A carry out of the top digit means the true sum exceeds 9999,
  // so the result pins at 9999 instead of wrapping.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] a,
                                              input logic [3:0]  b);
    logic [15:0] res;
    logic [4:0]  d;
    logic        c;
    res = '0;
    c   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[i*4 +: 4]} + ((i == 0) ? {1'b0, b} : 5'd0) + {4'b0, c};
      if (d > 5'd9) begin
        res[i*4 +: 4] = 4'(d - 5'd10);
        c             = 1'b1;
      end else begin
        res[i*4 +: 4] = d[3:0];
        c             = 1'b0;
      end
    end
    return c ? 16'h9999 : res;
  endfunction

endpackage

// File: rtl/bcd_score_acc.sv
// 4-digit BCD score accumulator, saturating at 9999, never decrements.
// Ports:
//   clk      in  1   accumulate clock
//   Reset    in  1   asynchronous, active-high; clears score to 0000
//   add_en   in  1   add add_val on this edge
//   add_val  in  4   BCD digit to add (0..9)
//   score    out 16  4 BCD digits, [15:12] most significant
module bcd_score_acc
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        Reset,
  input  logic        add_en,
  input  logic [3:0]  add_val,
  output logic [15:0] score
);

  logic [15:0] r_score;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)
      r_score <= 16'h0000;
    else if (add_en)
      r_score <= bcd_add_sat(r_score, add_val);
  end

  assign score = r_score;

endmodule

// File: rtl/bullet_hit_ctrl.sv
// Bullet/target hit controller. Each frame compares the live bullet box with
// the target box; on a hit it retires the bullet, sequences the target through
// flash / dead / respawn phases and bumps the BCD score.
// Ports:
//   frame_clk       in  1   one rising edge per video frame
//   Reset           in  1   asynchronous, active-high
//   bullet_on       in  1   bullet in flight; box inputs valid only when 1
//   BulletX/Y/S     in  10  bullet centre and half-size
//   TargetX/Y/S     in  10  target centre and half-size
//   hit             out 1   one-frame pulse after a registered hit
//   bullet_kill     out 1   one-frame pulse with hit, returns bullet to shooter
//   target_alive    out 1   target in ALIVE
//   target_visible  out 1   ALIVE, blinking in HIT, hidden in DEAD
//   score           out 16  4 BCD digits
//
// state | meaning
// ------+--------------------------------------------------------
// ALIVE | target shown, overlap checked every frame
// HIT   | target blinking for FLASH_FRAMES frames, overlap ignored
// DEAD  | target hidden for RESPAWN_FRAMES frames, overlap ignored
module bullet_hit_ctrl
  import game_pkg::*;
#(
  parameter int FLASH_FRAMES   = 30,
  parameter int RESPAWN_FRAMES = 120,
  parameter int POINTS         = 1,
  parameter int BLINK_BIT      = 2
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        bullet_on,
  input  logic [9:0]  BulletX,
  input  logic [9:0]  BulletY,
  input  logic [9:0]  BulletS,
  input  logic [9:0]  TargetX,
  input  logic [9:0]  TargetY,
  input  logic [9:0]  TargetS,
  output logic        hit,
  output logic        bullet_kill,
  output logic        target_alive,
  output logic        target_visible,
  output logic [15:0] score
);

  localparam logic [9:0] FLASH_LAST   = 10'(FLASH_FRAMES - 1);
  localparam logic [9:0] RESPAWN_LAST = 10'(RESPAWN_FRAMES - 1);
  localparam logic [3:0] POINTS_BCD   = 4'(POINTS);

  target_state_t r_state;
  logic [9:0]    r_frame_cnt;
  logic          r_hit;
  logic          r_kill;

  logic [10:0]   w_dx;
  logic [10:0]   w_dy;
  logic [10:0]   w_r;
  logic          w_overlap;
  logic          w_score_en;

  // Absolute differences taken by ordered subtraction so nothing wraps;
  // the radius sum needs the extra bit.
  assign w_dx = (BulletX >= TargetX) ? {1'b0, BulletX - TargetX}
                                     : {1'b0, TargetX - BulletX};
  assign w_dy = (BulletY >= TargetY) ? {1'b0, BulletY - TargetY}
                                     : {1'b0, TargetY - BulletY};
  assign w_r  = {1'b0, BulletS} + {1'b0, TargetS};

  assign w_overlap  = bullet_on & (w_dx <= w_r) & (w_dy <= w_r);
  assign w_score_en = (r_state == ALIVE) & w_overlap;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= ALIVE;
      r_frame_cnt <= '0;
      r_hit       <= 1'b0;
      r_kill      <= 1'b0;
    end else begin
      r_hit  <= 1'b0;
      r_kill <= 1'b0;
      case (r_state)
        ALIVE: begin
          if (w_overlap) begin
            r_state     <= HIT;
            r_frame_cnt <= '0;
            r_hit       <= 1'b1;
            r_kill      <= 1'b1;
          end
        end
        HIT: begin
          if (r_frame_cnt == FLASH_LAST) begin
            r_state     <= DEAD;
            r_frame_cnt <= '0;
          end else begin
            r_frame_cnt <= r_frame_cnt + 10'd1;
          end
        end
        DEAD: begin
          if (r_frame_cnt == RESPAWN_LAST) begin
            r_state     <= ALIVE;
            r_frame_cnt <= '0;
          end else begin
            r_frame_cnt <= r_frame_cnt + 10'd1;
          end
        end
        default: begin
          r_state     <= ALIVE;
          r_frame_cnt <= '0;
        end
      endcase
    end
  end

  bcd_score_acc u_score (
    .clk     (frame_clk),
    .Reset   (Reset),
    .add_en  (w_score_en),
    .add_val (POINTS_BCD),
    .score   (score)
  );

  assign hit            = r_hit;
  assign bullet_kill    = r_kill;
  assign target_alive   = (r_state == ALIVE);
  assign target_visible = (r_state == ALIVE) |
                          ((r_state == HIT) & ~r_frame_cnt[BLINK_BIT]);

endmodule

// File: tb/tb_bullet_hit_ctrl.sv
module tb_bullet_hit_ctrl;

  logic        frame_clk;
  logic        Reset;
  logic        bullet_on;
  logic [9:0]  BulletX, BulletY, BulletS;
  logic [9:0]  TargetX, TargetY, TargetS;

  logic        hit, bullet_kill, target_alive, target_visible;
  logic [15:0] score;
  logic        f1_hit, f1_kill, f1_alive, f1_vis;
  logic [15:0] f1_score;
  logic        f9_hit, f9_kill, f9_alive, f9_vis;
  logic [15:0] f9_score;

  int n_checks = 0;
  int n_fail   = 0;

  bullet_hit_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .bullet_on(bullet_on),
    .BulletX(BulletX), .BulletY(BulletY), .BulletS(BulletS),
    .TargetX(TargetX), .TargetY(TargetY), .TargetS(TargetS),
    .hit(hit), .bullet_kill(bullet_kill), .target_alive(target_alive),
    .target_visible(target_visible), .score(score)
  );

  bullet_hit_ctrl #(.FLASH_FRAMES(1), .RESPAWN_FRAMES(1), .POINTS(1)) dut_f1 (
    .frame_clk(frame_clk), .Reset(Reset), .bullet_on(bullet_on),
    .BulletX(BulletX), .BulletY(BulletY), .BulletS(BulletS),
    .TargetX(TargetX), .TargetY(TargetY), .TargetS(TargetS),
    .hit(f1_hit), .bullet_kill(f1_kill), .target_alive(f1_alive),
    .target_visible(f1_vis), .score(f1_score)
  );

  bullet_hit_ctrl #(.FLASH_FRAMES(1), .RESPAWN_FRAMES(1), .POINTS(9)) dut_f9 (
    .frame_clk(frame_clk), .Reset(Reset), .bullet_on(bullet_on),
    .BulletX(BulletX), .BulletY(BulletY), .BulletS(BulletS),
    .TargetX(TargetX), .TargetY(TargetY), .TargetS(TargetS),
    .hit(f9_hit), .bullet_kill(f9_kill), .target_alive(f9_alive),
    .target_visible(f9_vis), .score(f9_score)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic set_boxes(input logic on,
                           input int bx, input int by, input int bs,
                           input int tx, input int ty, input int ts);
    bullet_on = on;
    BulletX = 10'(bx); BulletY = 10'(by); BulletS = 10'(bs);
    TargetX = 10'(tx); TargetY = 10'(ty); TargetS = 10'(ts);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    set_boxes(1'b0, 0, 0, 0, 300, 300, 4);
    do_reset();
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL rst_hit: got %b want 0", hit); end
    n_checks++; if (bullet_kill !== 1'b0) begin n_fail++; $display("FAIL rst_kill: got %b want 0", bullet_kill); end
    n_checks++; if (target_alive !== 1'b1) begin n_fail++; $display("FAIL rst_alive: got %b want 1", target_alive); end
    n_checks++; if (target_visible !== 1'b1) begin n_fail++; $display("FAIL rst_visible: got %b want 1", target_visible); end
    n_checks++; if (score !== 16'h0000) begin n_fail++; $display("FAIL rst_score: got %h want 0000", score); end
  endtask

  task automatic test_basic_hit();
    do_reset();
    set_boxes(1'b1, 100, 100, 4, 106, 100, 4);
    tick();
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL basic_hit: got %b want 1", hit); end
    n_checks++; if (bullet_kill !== 1'b1) begin n_fail++; $display("FAIL basic_kill: got %b want 1", bullet_kill); end
    n_checks++; if (score !== 16'h0001) begin n_fail++; $display("FAIL basic_score: got %h want 0001", score); end
    n_checks++; if (target_alive !== 1'b0) begin n_fail++; $display("FAIL basic_alive: got %b want 0", target_alive); end
    tick();
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL basic_hit_clear: got %b want 0", hit); end
    n_checks++; if (bullet_kill !== 1'b0) begin n_fail++; $display("FAIL basic_kill_clear: got %b want 0", bullet_kill); end
  endtask

  task automatic test_boundary();
    do_reset();
    set_boxes(1'b1, 100, 100, 4, 109, 100, 4);   // dx=9, r=8
    tick();
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL bnd_dx9_hit: got %b want 0", hit); end
    n_checks++; if (score !== 16'h0000) begin n_fail++; $display("FAIL bnd_dx9_score: got %h want 0000", score); end
    set_boxes(1'b1, 100, 100, 4, 100, 91, 4);    // dy=9, r=8
    tick();
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL bnd_dy9_hit: got %b want 0", hit); end
    set_boxes(1'b1, 108, 100, 4, 100, 100, 4);   // dx=8 edge touch
    tick();
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL bnd_dx8_hit: got %b want 1", hit); end
    n_checks++; if (score !== 16'h0001) begin n_fail++; $display("FAIL bnd_dx8_score: got %h want 0001", score); end
    do_reset();
    set_boxes(1'b0, 200, 200, 8, 200, 200, 8);   // full overlap, bullet off
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL bnd_off_hit[%0d]: got %b want 0", i, hit); end
    end
    n_checks++; if (score !== 16'h0000) begin n_fail++; $display("FAIL bnd_off_score: got %h want 0000", score); end
  endtask

  task automatic test_phases();
    logic exp_vis;
    do_reset();
    set_boxes(1'b1, 100, 100, 4, 106, 100, 4);
    tick();
    for (int i = 0; i < 30; i++) begin
      exp_vis = ((i & 4) == 0);
      n_checks++; if (target_visible !== exp_vis) begin n_fail++; $display("FAIL ph_hit_vis[%0d]: got %b want %b", i, target_visible, exp_vis); end
      n_checks++; if (hit !== (i == 0)) begin n_fail++; $display("FAIL ph_hit_pulse[%0d]: got %b want %b", i, hit, (i == 0)); end
      n_checks++; if (target_alive !== 1'b0) begin n_fail++; $display("FAIL ph_hit_alive[%0d]: got %b want 0", i, target_alive); end
      tick();
    end
    for (int j = 0; j < 120; j++) begin
      n_checks++; if (target_visible !== 1'b0) begin n_fail++; $display("FAIL ph_dead_vis[%0d]: got %b want 0", j, target_visible); end
      n_checks++; if (hit !== 1'b0 || bullet_kill !== 1'b0) begin n_fail++; $display("FAIL ph_dead_pulse[%0d]: got %b%b want 00", j, hit, bullet_kill); end
      tick();
    end
    n_checks++; if (target_alive !== 1'b1) begin n_fail++; $display("FAIL ph_respawn_alive: got %b want 1", target_alive); end
    n_checks++; if (target_visible !== 1'b1) begin n_fail++; $display("FAIL ph_respawn_vis: got %b want 1", target_visible); end
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL ph_respawn_hit: got %b want 0", hit); end
    n_checks++; if (score !== 16'h0001) begin n_fail++; $display("FAIL ph_respawn_score: got %h want 0001", score); end
    tick();
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL ph_rehit: got %b want 1", hit); end
    n_checks++; if (score !== 16'h0002) begin n_fail++; $display("FAIL ph_rehit_score: got %h want 0002", score); end
  endtask

  task automatic test_bcd_carry();
    bit          seen;
    logic [15:0] exp;
    do_reset();
    set_boxes(1'b1, 100, 100, 4, 106, 100, 4);
    for (int h = 1; h <= 100; h++) begin
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
        tick();
        if (f1_hit === 1'b1) seen = 1'b1;
      end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL carry_hit_timeout[%0d]: got no pulse want pulse", h); end
      if (h >= 98) begin
        case (h)
          98:      exp = 16'h0098;
          99:      exp = 16'h0099;
          default: exp = 16'h0100;
        endcase
        n_checks++; if (f1_score !== exp) begin n_fail++; $display("FAIL carry_score[%0d]: got %h want %h", h, f1_score, exp); end
      end
    end
  endtask

  task automatic test_saturate();
    bit          seen;
    logic [15:0] exp;
    do_reset();
    set_boxes(1'b1, 100, 100, 4, 106, 100, 4);
    for (int h = 1; h <= 1112; h++) begin
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
        tick();
        if (f9_hit === 1'b1) seen = 1'b1;
      end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL sat_hit_timeout[%0d]: got no pulse want pulse", h); end
      if (h == 1 || h == 2 || h == 12 || h >= 1111) begin
        case (h)
          1:       exp = 16'h0009;
          2:       exp = 16'h0018;
          12:      exp = 16'h0108;
          default: exp = 16'h9999;
        endcase
        n_checks++; if (f9_score !== exp) begin n_fail++; $display("FAIL sat_score[%0d]: got %h want %h", h, f9_score, exp); end
      end
    end
    n_checks++; if (f9_kill !== 1'b1) begin n_fail++; $display("FAIL sat_kill: got %b want 1", f9_kill); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_boxes(1'b1, 100, 100, 4, 106, 100, 4);
    tick();
    set_boxes(1'b0, 100, 100, 4, 106, 100, 4);
    // Mid-frame reset while the hit pulse is high.
    #3;
    Reset = 1'b1;
    #1;
    n_checks++; if (hit !== 1'b0 || bullet_kill !== 1'b0) begin n_fail++; $display("FAIL ar_pulse_drop: got %b%b want 00", hit, bullet_kill); end
    n_checks++; if (score !== 16'h0000) begin n_fail++; $display("FAIL ar_hit_score: got %h want 0000", score); end
    tick();
    Reset = 1'b0;
    set_boxes(1'b1, 100, 100, 4, 106, 100, 4);
    tick();
    set_boxes(1'b0, 100, 100, 4, 106, 100, 4);
    for (int i = 0; i < 40; i++) tick();   // 30 in HIT, 10 into DEAD
    n_checks++; if (target_alive !== 1'b0 || target_visible !== 1'b0) begin n_fail++; $display("FAIL ar_in_dead: got %b%b want 00", target_alive, target_visible); end
    #3;
    Reset = 1'b1;
    #1;
    n_checks++; if (target_alive !== 1'b1) begin n_fail++; $display("FAIL ar_alive: got %b want 1", target_alive); end
    n_checks++; if (target_visible !== 1'b1) begin n_fail++; $display("FAIL ar_visible: got %b want 1", target_visible); end
    n_checks++; if (score !== 16'h0000) begin n_fail++; $display("FAIL ar_score: got %h want 0000", score); end
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL ar_hit: got %b want 0", hit); end
    tick();
    Reset = 1'b0;
    tick();
  endtask

  initial begin
    Reset = 1'b1;
    set_boxes(1'b0, 0, 0, 0, 300, 300, 4);
    test_reset();
    test_basic_hit();
    test_boundary();
    test_phases();
    test_bcd_carry();
    test_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
